isdft: RTL and testbench

ISDFT -- requirements
Module: isdft

---
 rtl/isdft_pkg.sv | 24 ++
 rtl/isdft_sat.sv | 35 +++
 rtl/isdft.sv | 157 +++++++++++++++
 tb/tb_isdft.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/isdft_pkg.sv
// isdft_pkg
//   Shared definitions for the isdft block: the controller state encoding and
//   the helpers that size the bin counter's terminal value and the
//   accumulator width from the block parameters.
package isdft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } isdft_state_t;

    // Index of the final bin of a block.
    function automatic int isdft_last(input int n, input bit half);
        return half ? (n / 2 - 1) : (n - 1);
    endfunction

    // Signed accumulator width. log2(n) growth covers n full-scale bins, and
    // the extra bit absorbs the x2 weighting applied in half-spectrum mode.
    function automatic int isdft_acc_w(input int idw, input int n);
        return idw + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/isdft_sat.sv
// isdft_sat
//   Combinational signed saturation from IW bits down to OW bits (OW < IW).
//   Ports:
//     i_data  signed IW-bit value to clip
//     o_data  signed OW-bit clipped value
//     o_clip  high when i_data does not fit in OW bits
module isdft_sat #(
    parameter int IW = 24,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] i_data,
    output logic signed [OW-1:0] o_data,
    output logic                 o_clip
);

    logic w_sign;
    logic w_fits;

    assign w_sign = i_data[IW-1];

    // The value fits when every bit from OW-1 upward is a copy of the sign.
    assign w_fits = (i_data[IW-1:OW-1] == {(IW-OW+1){w_sign}});

    always_comb begin
        o_clip = !w_fits;
        if (w_fits) begin
            o_data = i_data[OW-1:0];
        end else if (w_sign) begin
            o_data = {1'b1, {(OW-1){1'b0}}};
        end else begin
            o_data = {1'b0, {(OW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/isdft.sv
// isdft
//   Reduced inverse DFT that reconstructs the time-domain sample at n = 0
//   from one block of frequency bins: x = floor(sum(w_k * Re(X_k)) / N),
//   where w_k = 1 in full-spectrum mode, and in half-spectrum mode w_0 = 1 and
//   w_k = 2 for k >= 1 (the Nyquist bin is absent). The result is saturated
//   to DW bits.
//
//   state | meaning
//   IDLE  | waiting for a beat with sob_i
//   ACC   | accumulating bins, r_cnt holds the index of the next bin
//   EMIT  | output cycle; a new block may already start here
//
//   Ports:
//     clk_i        clock
//     arst_n_i     asynchronous active-low reset
//     data_i       bin, {imag, real} when IMAG_EN, real in [IDW-1:0]
//     valid_i      bin qualifier
//     sob_i        first bin of a block (with valid_i)
//     eob_i        last bin of a block (with valid_i)
//     data_o       reconstructed sample, held until the next valid_o
//     valid_o      one-cycle pulse with a new data_o
//     err_o        one-cycle pulse on a framing violation
//     sat_alarm_o  one-cycle pulse with valid_o when data_o was clipped
module isdft
    import isdft_pkg::*;
#(
    parameter int N        = 4096,
    parameter int IDW      = 32,
    parameter int DW       = 16,
    parameter int IMAG_EN  = 1,
    parameter     SPECTRUM = "full"
) (
    input  logic                                    clk_i,
    input  logic                                    arst_n_i,
    input  logic [(IMAG_EN != 0 ? 2*IDW : IDW)-1:0] data_i,
    input  logic                                    valid_i,
    input  logic                                    sob_i,
    input  logic                                    eob_i,
    output logic [DW-1:0]                           data_o,
    output logic                                    valid_o,
    output logic                                    err_o,
    output logic                                    sat_alarm_o
);

    localparam int              DIW    = (IMAG_EN != 0) ? 2*IDW : IDW;
    localparam bit              HALF   = (SPECTRUM == "half");
    localparam int              LOG2N  = $clog2(N);
    localparam int              CW     = LOG2N;
    localparam int              ACCW   = isdft_acc_w(IDW, N);
    localparam logic [CW-1:0]   LAST_C = CW'(isdft_last(N, HALF));

    isdft_state_t            r_state;
    logic signed [ACCW-1:0]  r_acc;
    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_data;
    logic                    r_valid;
    logic                    r_err;
    logic                    r_sat;

    logic signed [ACCW-1:0]  w_bin_ext;
    logic signed [ACCW-1:0]  w_bin_wt;
    logic signed [ACCW-1:0]  w_acc_next;
    logic signed [ACCW-1:0]  w_scaled;
    logic signed [DW-1:0]    w_sat;
    logic                    w_clip;

    // The imaginary half of the input word plays no part in x[0].
    generate
        if (IMAG_EN != 0) begin : g_imag
            logic w_unused_imag;
            assign w_unused_imag = ^data_i[DIW-1:IDW];
        end
    endgenerate

    assign w_bin_ext  = {{(ACCW-IDW){data_i[IDW-1]}}, data_i[IDW-1:0]};

    // Every bin reaching the adder has index >= 1 (bin 0 is loaded directly),
    // so in half mode the x2 weight applies unconditionally here.
    assign w_bin_wt   = HALF ? (w_bin_ext <<< 1) : w_bin_ext;
    assign w_acc_next = r_acc + w_bin_wt;

    // Arithmetic shift = divide by N rounding toward minus infinity.
    assign w_scaled   = w_acc_next >>> LOG2N;

    isdft_sat #(
        .IW (ACCW),
        .OW (DW)
    ) u_sat (
        .i_data (w_scaled),
        .o_data (w_sat),
        .o_clip (w_clip)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_sat   <= 1'b0;
            case (r_state)
                // EMIT only differs from IDLE in that valid_o is high; it
                // accepts a new sob so back-to-back blocks lose nothing.
                ST_IDLE, ST_EMIT: begin
                    r_state <= ST_IDLE;
                    if (valid_i) begin
                        if (sob_i && !eob_i) begin
                            r_acc   <= w_bin_ext;
                            r_cnt   <= CW'(1);
                            r_state <= ST_ACC;
                        end else begin
                            // stray beat, or sob+eob (a premature eob)
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (valid_i) begin
                        if (sob_i && !eob_i) begin
                            r_err <= 1'b1;
                            r_acc <= w_bin_ext;
                            r_cnt <= CW'(1);
                        end else if (eob_i && !sob_i && (r_cnt == LAST_C)) begin
                            r_data  <= w_sat;
                            r_valid <= 1'b1;
                            r_sat   <= w_clip;
                            r_state <= ST_EMIT;
                        end else if (eob_i || (r_cnt == LAST_C)) begin
                            r_err   <= 1'b1;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign err_o       = r_err;
    assign sat_alarm_o = r_sat;

endmodule

// File: tb/tb_isdft.sv
module tb_isdft;

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    logic [39:0] df, dh;
    logic        vf, sf, ef, vh, sh, eh;
    logic signed [15:0] dof, doh;
    logic        vof, eof_o, saf, voh, eoh, sah;

    always #5 clk = ~clk;

    isdft #(.N(8), .IDW(20), .DW(16), .IMAG_EN(1), .SPECTRUM("full")) dut_f (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(df), .valid_i(vf), .sob_i(sf), .eob_i(ef),
        .data_o(dof), .valid_o(vof), .err_o(eof_o), .sat_alarm_o(saf));

    isdft #(.N(8), .IDW(20), .DW(16), .IMAG_EN(1), .SPECTRUM("half")) dut_h (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(dh), .valid_i(vh), .sob_i(sh), .eob_i(eh),
        .data_o(doh), .valid_o(voh), .err_o(eoh), .sat_alarm_o(sah));

    int n_chk = 0;
    int n_bad = 0;
    int sel = 0;

    // reference model state
    longint blk[$];
    bit     in_blk = 0;
    bit     exp_valid = 0, exp_err = 0, exp_sat = 0;
    longint exp_data[2] = '{0, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (sel=%0d t=%0t): got %0d expected %0d", tag, sel, $time, got, exp);
        end
    endtask

    task automatic check_outs();
        if (sel == 0) begin
            chk("valid_o", longint'(vof), longint'(exp_valid));
            chk("err_o", longint'(eof_o), longint'(exp_err));
            chk("sat_alarm_o", longint'(saf), longint'(exp_sat));
            chk("data_o", longint'(dof), exp_data[0]);
        end else begin
            chk("valid_o", longint'(voh), longint'(exp_valid));
            chk("err_o", longint'(eoh), longint'(exp_err));
            chk("sat_alarm_o", longint'(sah), longint'(exp_sat));
            chk("data_o", longint'(doh), exp_data[1]);
        end
    endtask

    // x[0] = floor(sum of weighted real parts / 8), clipped to 16-bit signed
    task automatic model_emit();
        longint sum = 0;
        longint q;
        for (int i = 0; i < blk.size(); i++)
            sum += (sel == 1 && i > 0) ? 2 * blk[i] : blk[i];
        q = sum / 8;
        if ((sum % 8) != 0 && sum < 0) q = q - 1;
        exp_sat = 0;
        if (q > 32767) begin q = 32767; exp_sat = 1; end
        if (q < -32768) begin q = -32768; exp_sat = 1; end
        exp_valid = 1;
        exp_data[sel] = q;
    endtask

    task automatic model(input bit v, input longint re, input bit s, input bit e);
        int last;
        int idx;
        last = (sel == 1) ? 3 : 7;
        exp_valid = 0; exp_err = 0; exp_sat = 0;
        if (!v) return;
        if (s && e) begin
            exp_err = 1; in_blk = 0; blk.delete();
        end else if (s) begin
            if (in_blk) exp_err = 1;
            blk.delete(); blk.push_back(re); in_blk = 1;
        end else if (!in_blk) begin
            exp_err = 1;
        end else begin
            idx = blk.size();
            blk.push_back(re);
            if (e) begin
                if (idx == last) model_emit(); else exp_err = 1;
                in_blk = 0; blk.delete();
            end else if (idx == last) begin
                exp_err = 1; in_blk = 0; blk.delete();
            end
        end
    endtask

    task automatic cyc(input bit v, input int re, input int im, input bit s, input bit e);
        logic [31:0] r32, i32;
        logic [39:0] w;
        @(negedge clk);
        check_outs();
        r32 = re; i32 = im;
        w = {i32[19:0], r32[19:0]};
        if (sel == 0) begin
            df = w; vf = v; sf = s; ef = e; dh = '0; vh = 0; sh = 0; eh = 0;
        end else begin
            dh = w; vh = v; sh = s; eh = e; df = '0; vf = 0; sf = 0; ef = 0;
        end
        model(v, longint'(re), s, e);
    endtask

    task automatic beat(input int re, input bit s, input bit e);
        cyc(1, re, int'($urandom_range(0, 1048575)), s, e);
    endtask

    task automatic gap();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outs();
        arst_n = 0;
        df = '0; vf = 0; sf = 0; ef = 0; dh = '0; vh = 0; sh = 0; eh = 0;
        #1;
        in_blk = 0; blk.delete();
        exp_valid = 0; exp_err = 0; exp_sat = 0;
        exp_data[0] = 0; exp_data[1] = 0;
        check_outs();
        @(negedge clk);
        arst_n = 1;
    endtask

    task automatic const_blk(input int n, input int v0, input int vr);
        for (int i = 0; i < n; i++)
            beat((i == 0) ? v0 : vr, i == 0, i == n - 1);
    endtask

    function automatic int rnd_re();
        if ($urandom_range(0, 1) == 0)
            return int'($urandom_range(0, 200)) - 100;
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    task automatic rblk(input int len, input bit put_eob, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) gap();
            beat(rnd_re(), i == 0, put_eob && (i == len - 1));
        end
    endtask

    task automatic random_phase(input int iters);
        int last;
        int kind;
        last = (sel == 1) ? 3 : 7;
        for (int it = 0; it < iters; it++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: rblk(int'($urandom_range(1, last)), 1, 1);
                1: rblk(last + 1, 0, 1);
                2: rblk(int'($urandom_range(1, last)), 0, 0);
                3: beat(rnd_re(), 0, $urandom_range(0, 1) == 1);
                default: rblk(last + 1, 1, $urandom_range(0, 1) == 1);
            endcase
            if ($urandom_range(0, 2) == 0) gap();
        end
    endtask

    initial begin
        df = '0; vf = 0; sf = 0; ef = 0; dh = '0; vh = 0; sh = 0; eh = 0;
        #3;
        check_outs();
        @(negedge clk);
        arst_n = 1;

        // full spectrum directed
        sel = 0;
        for (int i = 0; i < 8; i++) cyc(1, 8, 123, i == 0, i == 7);
        gap();
        beat(80, 1, 0); beat(0, 0, 0); beat(0, 0, 0); gap();
        beat(0, 0, 0); beat(0, 0, 0); gap();
        beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 1);
        const_blk(8, -3, -3);
        const_blk(8, -1, -1);
        const_blk(8, 524287, 524287);
        const_blk(8, -524288, -524288);
        gap();
        // eob at bin 5, then a good block
        const_blk(6, 40, 40);
        const_blk(8, 16, 16);
        // sob at bin 3 restarts, block ends with good data
        for (int i = 0; i < 3; i++) beat(1000, i == 0, 0);
        const_blk(8, 24, 0);
        // bin 7 without eob, then stray beats
        for (int i = 0; i < 8; i++) beat(5, i == 0, 0);
        beat(5, 0, 1);
        gap();
        // reset at bin 4
        for (int i = 0; i < 4; i++) beat(800, i == 0, 0);
        do_reset();
        gap();
        const_blk(8, 64, 8);
        gap();
        random_phase(40);
        gap(); gap();

        // half spectrum
        do_reset();
        sel = 1;
        const_blk(4, 8, 4);
        const_blk(4, 1, 0);
        const_blk(4, -8, -4);
        const_blk(2, 3, 3);
        const_blk(4, 524287, 524287);
        random_phase(40);
        gap(); gap();
        @(negedge clk);
        check_outs();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
